// File: rtl/gf180mcu_icg_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_icg_ctrl_pkg : shared channel state type and default parameters
// Rev 1.0
// ---------------------------------------------------------------------------
package gf180mcu_icg_ctrl_pkg;

  localparam int N_DEF        = 4;
  localparam int CW_DEF       = 8;
  localparam int WAKE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    PEND = 3'd1,
    WAKE = 3'd2,
    ON   = 3'd3,
    IDLE = 3'd4
  } chan_state_t;

  // Index width that stays legal (>=1 bit) for a single-entry range.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180mcu_icg_ctrl_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_icg_ctrl_chan : one gated-clock channel FSM with wake/idle counters
// Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_icg_ctrl_chan
  import gf180mcu_icg_ctrl_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          act,
  input  logic          grant,
  input  logic [CW-1:0] idle_lim,
  output logic          pend,
  output logic          in_wake,
  output logic          wake_done,
  output logic          en_q,
  output logic          ack
);

  localparam int            WW    = bits_for(WAKE_CYC);
  localparam logic [WW-1:0] WLOAD = WW'(WAKE_CYC - 1);

  chan_state_t   state, state_nxt;
  logic [CW-1:0] icnt, icnt_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      icnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      icnt  <= icnt_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    icnt_nxt  = icnt;
    wcnt_nxt  = wcnt;
    case (state)
      OFF: begin
        if (act) state_nxt = PEND;
      end
      // A grant issued in the same cycle that act falls still wins: the slot
      // was already committed by the arbiter.
      PEND: begin
        if (grant) begin
          state_nxt = WAKE;
          wcnt_nxt  = WLOAD;
        end else if (!act) begin
          state_nxt = OFF;
        end
      end
      WAKE: begin
        if (wcnt == '0) state_nxt = ON;
        else            wcnt_nxt  = wcnt - 1'b1;
      end
      ON: begin
        if (!act) begin
          if (idle_lim == '0) begin
            state_nxt = OFF;
          end else begin
            state_nxt = IDLE;
            icnt_nxt  = idle_lim - 1'b1;
          end
        end
      end
      IDLE: begin
        if (act) begin
          state_nxt = ON;
          icnt_nxt  = '0;
        end else if (icnt == '0) begin
          state_nxt = OFF;
        end else begin
          icnt_nxt  = icnt - 1'b1;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  assign pend      = (state == PEND);
  assign in_wake   = (state == WAKE);
  assign wake_done = (state == WAKE) && (wcnt == '0);
  assign en_q      = (state == WAKE) || (state == ON) || (state == IDLE);
  assign ack       = (state == ON) || (state == IDLE);

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__icg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__icg_ctrl : N-channel ICG enable sequencer with
// round-robin staggered wake-up. Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__icg_ctrl
  import gf180mcu_icg_ctrl_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int CW       = CW_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TE,
  input  logic [N-1:0]           REQ,
  input  logic [N-1:0]           FORCE_ON,
  input  logic [CW-1:0]          IDLE_LIM,
  output logic [N-1:0]           EN,
  output logic [N-1:0]           ACK,
  output logic [bits_for(N)-1:0] WAKE_ID
);

  localparam int IW = bits_for(N);

  logic [N-1:0]  pend, in_wake, wake_done, en_q, ack_q, grant;
  logic [IW-1:0] ptr, wake_id, grant_idx, sel;
  logic          slot_free, grant_any;
  int            idx;

  for (genvar i = 0; i < N; i++) begin : g_chan
    gf180mcu_icg_ctrl_chan #(
      .CW       (CW),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk       (CLK),
      .rst       (RST),
      .act       (REQ[i] | FORCE_ON[i]),
      .grant     (grant[i]),
      .idle_lim  (IDLE_LIM),
      .pend      (pend[i]),
      .in_wake   (in_wake[i]),
      .wake_done (wake_done[i]),
      .en_q      (en_q[i]),
      .ack       (ack_q[i])
    );
  end

  // A channel finishing its wake this cycle hands the slot straight on.
  assign slot_free = ~|(in_wake & ~wake_done);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    if (slot_free) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        sel = IW'(idx);
        if (!grant_any && pend[sel]) begin
          grant_any   = 1'b1;
          grant_idx   = sel;
          grant[sel]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr     <= '0;
      wake_id <= '0;
    end else if (grant_any) begin
      ptr     <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      wake_id <= grant_idx;
    end
  end

  assign EN      = en_q | {N{TE}};
  assign ACK     = ack_q;
  assign WAKE_ID = wake_id;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__icg_ctrl.sv
`default_nettype none
// Bench for the ICG controller: directed vector table, hand-written corner
// sequences and a randomized run against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu9t5v0__icg_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          te = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  force_on = '0;
  logic [CW-1:0] idle_lim = 8'd3;
  logic [N-1:0]  en, ack;
  logic [1:0]    wake_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: phase 0=off 1=waiting 2=waking 3=running, with absolute
  // edge numbers for when ACK rises and when the clock gates off.
  int ph[N];
  int ack_at[N];
  int off_at[N];
  int m_ptr = 0;
  int m_wid = 0;

  gf180mcu_fd_sc_mcu9t5v0__icg_ctrl #(.N(N), .CW(CW), .WAKE_CYC(WC)) dut (
    .CLK      (clk),
    .RST      (rst),
    .TE       (te),
    .REQ      (req),
    .FORCE_ON (force_on),
    .IDLE_LIM (idle_lim),
    .EN       (en),
    .ACK      (ack),
    .WAKE_ID  (wake_id)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input int c);
    int g;
    bit slot;
    bit a;
    if (rst) begin
      for (int i = 0; i < N; i++) begin ph[i] = 0; off_at[i] = -1; end
      m_ptr = 0;
      m_wid = 0;
      return;
    end
    slot = 1'b1;
    for (int i = 0; i < N; i++) if (ph[i] == 2 && ack_at[i] != c) slot = 1'b0;
    g = -1;
    if (slot)
      for (int k = 0; k < N; k++)
        if (g < 0 && ph[(m_ptr + k) % N] == 1) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      a = req[i] | force_on[i];
      case (ph[i])
        0: if (a) ph[i] = 1;
        1: begin
          if (i == g) begin ph[i] = 2; ack_at[i] = c + WC; end
          else if (!a) ph[i] = 0;
        end
        2: if (c == ack_at[i]) begin ph[i] = 3; off_at[i] = -1; end
        default: begin
          if (a) off_at[i] = -1;
          else if (off_at[i] < 0) begin
            if (idle_lim == 0) ph[i] = 0;
            else off_at[i] = c + int'(idle_lim);
          end else if (c == off_at[i]) ph[i] = 0;
        end
      endcase
    end
    if (g >= 0) begin m_ptr = (g + 1) % N; m_wid = g; end
  endtask

  function automatic int m_en();
    int v = 0;
    for (int i = 0; i < N; i++) if (ph[i] >= 2 || te) v |= (1 << i);
    return v;
  endfunction

  function automatic int m_ack();
    int v = 0;
    for (int i = 0; i < N; i++) if (ph[i] == 3) v |= (1 << i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(cyc);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int e_en, input int e_ack, input int e_wid);
    check({name, "_en"},  int'(en),      e_en);
    check({name, "_ack"}, int'(ack),     e_ack);
    check({name, "_wid"}, int'(wake_id), e_wid);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; force_on = '0; te = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic       do_edge;
    logic       rst;
    logic       te;
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] ack;
    logic [1:0] wid;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int e_en, e_ack, e_wid;

    for (int i = 0; i < N; i++) begin ph[i] = 0; off_at[i] = -1; ack_at[i] = 0; end

    // Single short request on ch1, IDLE_LIM=3, then TE overlay with all OFF.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'h0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'h0, 4'h0, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h0, 2'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h0, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h2, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h2, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h2, 2'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h2, 4'h2, 2'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0, 2'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'hF, 4'h0, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0, 2'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0, 2'd1};

    // Reset then idle inputs for 5 cycles.
    do_reset();
    check_all("rst", int'(en), 0, 0);
    check_all("rst0", 0, 0, 0);
    for (int e = 0; e < 5; e++) begin
      step();
      check_all($sformatf("quiet%0d", e), 0, 0, 0);
    end

    idle_lim = 8'd3;
    foreach (tbl[r]) begin
      rst = tbl[r].rst;
      te  = tbl[r].te;
      req = tbl[r].req;
      if (tbl[r].do_edge) step();
      else #1;
      check_all($sformatf("tbl%0d", r), int'(tbl[r].en), int'(tbl[r].ack), int'(tbl[r].wid));
    end

    // All four request together: staggered grants every WC edges.
    do_reset();
    req = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      step();
      e_en = 0; e_ack = 0;
      for (int i = 0; i < N; i++) begin
        if (e >= 2 + WC * i) e_en  |= (1 << i);
        if (e >= 2 + WC * i + WC) e_ack |= (1 << i);
      end
      e_wid = (e < 2) ? 0 : (((e - 2) / WC > 3) ? 3 : (e - 2) / WC);
      check_all($sformatf("stagger%0d", e), e_en, e_ack, e_wid);
    end

    // Ch2 re-requests during IDLE; then release with IDLE_LIM=0.
    do_reset();
    idle_lim = 8'd5;
    req = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 2) check("reidle_wid", int'(wake_id), 2);
      if (e >= 4) begin
        check($sformatf("reidle_en%0d", e), int'(en), 4'b0100);
        check($sformatf("reidle_ack%0d", e), int'(ack), 4'b0100);
      end
      if (e == 5) req = 4'b0000;
      if (e == 8) req = 4'b0100;
    end
    idle_lim = 8'd0;
    req = 4'b0000;
    step();
    check_all("lim0_off", 0, 0, 2);

    // Reset during ch0 WAKE and ch3 IDLE.
    do_reset();
    idle_lim = 8'd5;
    req = 4'b1000;
    for (int e = 1; e <= 4; e++) step();
    check_all("mid_ch3on", 4'b1000, 4'b1000, 3);
    req = 4'b0001;
    step();
    step();
    check_all("mid_pre_rst", 4'b1001, 4'b1000, 0);
    rst = 1'b1;
    step();
    check_all("mid_rst", 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("mid_pend", 0, 0, 0);
    step();
    check_all("mid_wake", 4'b0001, 0, 0);
    step();
    step();
    check_all("mid_ack", 4'b0001, 4'b0001, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)  req[i]      = ~req[i];
        if ($urandom_range(0, 15) == 0) force_on[i] = ~force_on[i];
      end
      if ($urandom_range(0, 15) == 0) te = ~te;
      idle_lim = CW'($urandom_range(0, 6));
      step();
      check_all($sformatf("rand%0d", t), m_en(), m_ack(), m_wid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
